// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared 32-bit ALU: round-robin grant,
// operands latched at grant, one result/zero register pair per requester.

module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  f,
  output logic [31:0] y
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves y unassigned (no latch).
    y = '0;
    case (f)
      3'b000: y = a & b;
      3'b001: y = a | b;
      3'b010: y = a + b;
      3'b011: y = '0;
      3'b100: y = a & ~b;
      3'b101: y = a | ~b;
      3'b110: y = a - b;
      3'b111: y = {31'b0, $signed(a) < $signed(b)};
      default: y = '0;
    endcase
  end

endmodule

module alu_arbiter #(
  parameter int PRIO_FIRST = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] srca0,
  input  logic [31:0] srcb0,
  input  logic [2:0]  alucontrol0,
  output logic        gnt0,
  output logic        done0,
  output logic [31:0] result0,
  output logic        zero0,
  input  logic        req1,
  input  logic [31:0] srca1,
  input  logic [31:0] srcb1,
  input  logic [2:0]  alucontrol1,
  output logic        gnt1,
  output logic        done1,
  output logic [31:0] result1,
  output logic        zero1,
  output logic        busy
);

  typedef enum logic {IDLE, EXEC} state_t;

  // Last winner starts as the opposite of PRIO_FIRST so PRIO_FIRST takes the first tie.
  localparam logic LAST_RESET = (PRIO_FIRST == 0) ? 1'b1 : 1'b0;

  state_t      state, state_next;
  logic        grant, sel;
  logic        winner, last_winner;
  logic [31:0] a_q, b_q, aluresult;
  logic [2:0]  op_q;

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    sel        = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant      = 1'b1;
          state_next = EXEC;
          sel        = (req0 && req1) ? ~last_winner : req1;
        end
      end
      EXEC:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  alu u_alu (
    .a (a_q),
    .b (b_q),
    .f (op_q),
    .y (aluresult)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the operand latch is reset too, so the ALU never sees X after power-up.
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      winner      <= 1'b0;
      last_winner <= LAST_RESET;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      result0     <= '0;
      result1     <= '0;
      zero0       <= 1'b0;
      zero1       <= 1'b0;
    end else begin
      gnt0  <= grant && !sel;
      gnt1  <= grant && sel;
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (grant) begin
        a_q         <= sel ? srca1 : srca0;
        b_q         <= sel ? srcb1 : srcb0;
        op_q        <= sel ? alucontrol1 : alucontrol0;
        winner      <= sel;
        last_winner <= sel;
      end
      if (state == EXEC) begin
        if (winner) begin
          result1 <= aluresult;
          zero1   <= (aluresult == '0);
          done1   <= 1'b1;
        end else begin
          result0 <= aluresult;
          zero0   <= (aluresult == '0);
          done0   <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == EXEC);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed plan steps plus randomized
// transactions checked against a transaction-level reference model.

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] srca0, srcb0, srca1, srcb1;
  logic [2:0]  alucontrol0, alucontrol1;
  logic        gnt0, gnt1, done0, done1, zero0, zero1, busy;
  logic [31:0] result0, result1;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic        m_last;
  logic [31:0] m_res0, m_res1;
  logic        m_zero0, m_zero1;

  alu_arbiter #(.PRIO_FIRST(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .srca0       (srca0),
    .srcb0       (srcb0),
    .alucontrol0 (alucontrol0),
    .gnt0        (gnt0),
    .done0       (done0),
    .result0     (result0),
    .zero0       (zero0),
    .req1        (req1),
    .srca1       (srca1),
    .srcb1       (srcb1),
    .alucontrol1 (alucontrol1),
    .gnt1        (gnt1),
    .done1       (done1),
    .result1     (result1),
    .zero1       (zero1),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return 32'(64'(a) + 64'(b));
      3'd3: return 32'd0;
      3'd4: return a & ~b;
      3'd5: return a | ~b;
      3'd6: return 32'(64'(a) - 64'(b));
      default: return (sa < sb) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_last  = 1'b1;
    m_res0  = '0;
    m_res1  = '0;
    m_zero0 = 1'b0;
    m_zero1 = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_result0"}, result0, m_res0);
    check({tag, "_zero0"},   zero0,   m_zero0);
    check({tag, "_result1"}, result1, m_res1);
    check({tag, "_zero1"},   zero1,   m_zero1);
  endtask

  task automatic idle_cycle(input string tag);
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    check({tag, "_gnt0"},  gnt0,  0);
    check({tag, "_gnt1"},  gnt1,  0);
    check({tag, "_busy"},  busy,  0);
    check({tag, "_done0"}, done0, 0);
    check({tag, "_done1"}, done1, 0);
    check_outputs(tag);
  endtask

  // One full transaction, entered in an IDLE cycle; returns in the done cycle
  // with both requests dropped. scramble disturbs all inputs during EXEC.
  task automatic op_cycle(input string tag,
                          input logic r0, input logic [31:0] a0, input logic [31:0] b0,
                          input logic [2:0] c0,
                          input logic r1, input logic [31:0] a1, input logic [31:0] b1,
                          input logic [2:0] c1, input bit scramble);
    logic        w;
    logic [31:0] exp;
    req0 = r0; srca0 = a0; srcb0 = b0; alucontrol0 = c0;
    req1 = r1; srca1 = a1; srcb1 = b1; alucontrol1 = c1;
    w   = (r0 && r1) ? !m_last : r1;
    exp = w ? alu_ref(a1, b1, c1) : alu_ref(a0, b0, c0);
    step();
    check({tag, "_gnt0"},  gnt0,  !w);
    check({tag, "_gnt1"},  gnt1,  w);
    check({tag, "_busy"},  busy,  1);
    check({tag, "_xdone"}, done0 | done1, 0);
    if (scramble) begin
      srca0 = srca0 + 32'd95;
      srcb0 = $urandom;
      alucontrol0 = 3'($urandom);
      srca1 = $urandom;
      srcb1 = $urandom;
      alucontrol1 = 3'($urandom);
      req0 = 1'($urandom);
      req1 = 1'b1;
    end
    m_last = w;
    if (w) begin
      m_res1 = exp; m_zero1 = (exp == 0);
    end else begin
      m_res0 = exp; m_zero0 = (exp == 0);
    end
    step();
    check({tag, "_done0"}, done0, !w);
    check({tag, "_done1"}, done1, w);
    check({tag, "_idle"},  busy,  0);
    check({tag, "_ngnt"},  gnt0 | gnt1, 0);
    check_outputs(tag);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0 = 0; srca0 = 0; srcb0 = 0; alucontrol0 = 0;
    req1 = 0; srca1 = 0; srcb1 = 0; alucontrol1 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", {30'b0, gnt0, gnt1}, 0);
    check("rst_done", {30'b0, done0, done1}, 0);
    check("rst_busy", busy, 0);
    check_outputs("rst");
    reset = 1'b0;

    idle_cycle("idle");

    // Single add on requester 0
    op_cycle("add0", 1, 32'd5, 32'd7, 3'b010, 0, 32'd0, 32'd0, 3'b000, 0);
    check("add0_val", result0, 32'd12);

    // Subtract and signed SLT on requester 1
    op_cycle("sub1", 0, 0, 0, 0, 1, 32'd3, 32'd3, 3'b110, 0);
    check("sub1_zero", zero1, 1);
    op_cycle("slt1a", 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'd1, 3'b111, 0);
    check("slt1a_val", result1, 32'd1);
    op_cycle("slt1b", 0, 0, 0, 0, 1, 32'd1, 32'hFFFF_FFFF, 3'b111, 0);
    check("slt1b_val", result1, 32'd0);

    // Tie held across back-to-back grants: order 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      op_cycle($sformatf("tie%0d", i), 1, 32'hF0, 32'h0F, 3'b001,
               1, 32'hF0, 32'h0F, 3'b000, 0);
    end
    check("tie_res0", result0, 32'hFF);
    check("tie_zero1", zero1, 1);

    // Inputs changed during EXEC are ignored; a req1 pulse only in EXEC gets nothing
    op_cycle("ign", 1, 32'd5, 32'd7, 3'b010, 0, 0, 0, 0, 1);
    check("ign_val", result0, 32'd12);
    idle_cycle("ign_post");

    // Reset during EXEC aborts the op
    req0 = 1; srca0 = 32'd9; srcb0 = 32'd1; alucontrol0 = 3'b010;
    step();
    check("rmid_gnt0", gnt0, 1);
    reset = 1'b1;
    req0  = 1'b0;
    step();
    model_reset();
    check("rmid_done0", done0, 0);
    check("rmid_busy", busy, 0);
    check_outputs("rmid");
    reset = 1'b0;
    op_cycle("rtie", 1, 32'd2, 32'd1, 3'b110, 1, 32'd4, 32'd4, 3'b010, 0);
    check("rtie_res0", result0, 32'd1);

    // Constant-zero op
    op_cycle("c0", 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 32'd1, 3'b011, 0);
    check("c0_zero", zero1, 1);

    // Randomized transactions, sometimes with an idle gap
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  pat;
      logic [31:0] ra0, rb0, ra1, rb1;
      pat = 2'($urandom_range(3, 1));
      ra0 = $urandom; rb0 = ($urandom_range(3, 0) == 0) ? ra0 : $urandom;
      ra1 = $urandom; rb1 = ($urandom_range(3, 0) == 0) ? ra1 : $urandom;
      op_cycle($sformatf("rnd%0d", i), pat[0], ra0, rb0, 3'($urandom),
               pat[1], ra1, rb1, 3'($urandom), 1'($urandom));
      if ($urandom_range(3, 0) == 0) idle_cycle($sformatf("rgap%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
